// File: rtl/ccff_chain_loader_if.sv
// Configuration word stream into the ccff chain loader (valid/ready).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words LSB-first into the tile ccff chain and
// releases fabric I/O isolation only after the chain tail has been verified.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; done/error/IO_ISOL_N hold last result
// S_LOAD  | accepting words and shifting one bit per enabled prog_clk
// S_CHECK | chain fully loaded; compare ccff_tail against first bit
// S_DONE  | result published, busy low; back to idle next cycle
module ccff_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               start,
  ccff_chain_loader_if.slave cfg,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               prog_clk_en,
  output logic               IO_ISOL_N,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   bit_count
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int WL_W      = $clog2(NWORDS + 1);
  localparam int SC_W      = $clog2(WORD_W + 1);

  localparam logic [WL_W-1:0]  NWORDS_C = WL_W'(NWORDS);
  localparam logic [SC_W-1:0]  WORD_C   = SC_W'(WORD_W);
  localparam logic [SC_W-1:0]  LAST_C   = SC_W'(LAST_BITS);
  localparam logic [CNT_W-1:0] CHAIN_C  = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WL_W-1:0]    words_left_q, words_left_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [SC_W-1:0]    scnt_q, scnt_d;
  logic [WORD_W-1:0]  hreg_q, hreg_d;
  logic               hfull_q, hfull_d;
  logic               hlast_q, hlast_d;
  logic               first_q, first_d;

  logic               head_d, en_d, iso_d, busy_d, done_d, error_d, ready_d;
  logic [CNT_W-1:0]   bit_count_d;

  logic               accept, refill, last_in;
  logic [WORD_W-1:0]  in_word;
  logic [SC_W-1:0]    in_bits;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q       <= S_IDLE;
      words_left_q  <= '0;
      sreg_q        <= '0;
      scnt_q        <= '0;
      hreg_q        <= '0;
      hfull_q       <= 1'b0;
      hlast_q       <= 1'b0;
      first_q       <= 1'b0;
      ccff_head     <= 1'b0;
      prog_clk_en   <= 1'b0;
      IO_ISOL_N     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      bit_count     <= '0;
      cfg.cfg_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      words_left_q  <= words_left_d;
      sreg_q        <= sreg_d;
      scnt_q        <= scnt_d;
      hreg_q        <= hreg_d;
      hfull_q       <= hfull_d;
      hlast_q       <= hlast_d;
      first_q       <= first_d;
      ccff_head     <= head_d;
      prog_clk_en   <= en_d;
      IO_ISOL_N     <= iso_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
      bit_count     <= bit_count_d;
      cfg.cfg_ready <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    sreg_d       = sreg_q;
    scnt_d       = scnt_q;
    hreg_d       = hreg_q;
    hfull_d      = hfull_q;
    hlast_d      = hlast_q;
    first_d      = first_q;
    head_d       = ccff_head;
    en_d         = 1'b0;
    iso_d        = IO_ISOL_N;
    busy_d       = busy;
    done_d       = done;
    error_d      = error;
    bit_count_d  = bit_count;
    refill       = 1'b0;
    accept       = cfg.cfg_valid & cfg.cfg_ready;
    last_in      = (words_left_q == WL_W'(1));
    // A word arriving with the holding register empty is treated as if it
    // were already held, so the first bit goes out on the very next cycle.
    in_word      = hfull_q ? hreg_q : cfg.cfg_data;
    in_bits      = (hfull_q ? hlast_q : last_in) ? LAST_C : WORD_C;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          iso_d        = 1'b0;
          bit_count_d  = '0;
          words_left_d = NWORDS_C;
          scnt_d       = '0;
          hfull_d      = 1'b0;
        end
      end

      S_LOAD: begin
        if (bit_count == CHAIN_C) begin
          state_d = S_CHECK;
        end else begin
          refill = (scnt_q <= SC_W'(1)) && (hfull_q || accept);
          if (accept) begin
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == NWORDS_C) first_d = cfg.cfg_data[0];
            if (!refill) begin
              hreg_d  = cfg.cfg_data;
              hfull_d = 1'b1;
              hlast_d = last_in;
            end
          end else if (refill) begin
            hfull_d = 1'b0;
          end

          if (scnt_q != '0) begin
            head_d      = sreg_q[0];
            en_d        = 1'b1;
            bit_count_d = bit_count + 1'b1;
            if (refill) begin
              sreg_d = in_word;
              scnt_d = in_bits;
            end else begin
              sreg_d = sreg_q >> 1;
              scnt_d = scnt_q - 1'b1;
            end
          end else if (refill) begin
            head_d      = in_word[0];
            en_d        = 1'b1;
            bit_count_d = bit_count + 1'b1;
            sreg_d      = in_word >> 1;
            scnt_d      = in_bits - 1'b1;
          end
        end
      end

      S_CHECK: begin
        busy_d  = 1'b0;
        state_d = S_DONE;
        if (ccff_tail != first_q) begin
          error_d = 1'b1;
        end else begin
          done_d = 1'b1;
          iso_d  = 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    ready_d = busy_d & ~hfull_d & (words_left_d != '0);
  end

endmodule
